hs_rx_packer: RTL and testbench
===============================

HS_RX_PACKER -- requirements
Module: hs_rx_packer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: the byte width received from the handshake destination side.
REQ-002 The block SHALL have parameter PACK, default 4: the number of bytes per output word.
REQ-003 The block SHALL have parameter DEPTH, default 4: the number of output word FIFO entries, a power of two.
REQ-004 Port clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst_n, input, 1: the reset, asynchronous and active-low.
REQ-006 Port in_valid, input, 1: one-cycle byte strobe, connected to dvalid of the handshake destination.
REQ-007 Port in_data, input, WIDTH: the byte, valid only while in_valid=1.
REQ-008 Port busy, output, 1: back-pressure to the handshake, connected to its dbusy input.
REQ-009 Port out_valid, output, 1: the FIFO head word is available.
REQ-010 Port out_ready, input, 1: the downstream accepts the head word.
REQ-011 Port out_data, output, WIDTH*PACK: the FIFO head word.
REQ-012 Port overflow, output, 1: sticky flag showing a word was dropped.

Function
REQ-013 A byte counter (0..PACK-1) SHALL advance by one on each in_valid.
- It SHALL wrap to 0 after PACK-1.
REQ-014 Byte k of a word (k = counter value on arrival) SHALL be placed in out_data bits [k*WIDTH +: WIDTH], little-endian: the first byte goes to the LSBs.
REQ-015 When the PACK-th byte arrives in cycle t, the assembled word SHALL be pushed into the FIFO at the end of cycle t.
- out_valid SHALL be 1 in cycle t+1 if the FIFO was empty.
REQ-016 A pop SHALL occur in any cycle where out_valid=1 and out_ready=1.
- out_data SHALL show the next entry in the following cycle.
REQ-017 out_valid SHALL equal (fifo_count != 0), driven from registers.
- out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-018 A push SHALL be accepted when fifo_count < DEPTH, or when a pop occurs in the same cycle.
- On a simultaneous push and pop, fifo_count SHALL stay unchanged.
REQ-019 If a push is not accepted, the block SHALL:
- drop the word;
- set overflow to 1 in the next cycle;
- hold overflow at 1 until reset;
- still wrap the byte counter to 0.
REQ-020 busy SHALL be a registered output.
- It SHALL be 1 in the cycle after any cycle whose next-state fifo_count >= DEPTH-1.
- Otherwise it SHALL be 0.
- This leaves one word of slack for bytes already in flight through the synchronizer.
REQ-021 Bytes arriving while busy=1 SHALL still be accepted into the partial word.
- busy is advisory; only REQ-019 causes loss.
REQ-022 FIFO read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH.
- fifo_count SHALL be log2(DEPTH)+1 bits wide.

Reset
REQ-023 Asserting rst_n=0 at any time, including in the middle of a word, SHALL asynchronously clear:
- the byte counter;
- the partial word;
- the FIFO pointers and count;
- busy, out_valid, out_data and overflow, all to 0.
REQ-024 After reset release, the first in_valid SHALL be treated as byte 0 of a new word.

Structure
REQ-025 A shared package SHALL hold:
- defaults for WIDTH, PACK and DEPTH;
- the derived pointer width and count width constants;
- the word type of WIDTH*PACK bits.
REQ-026 The FIFO SHALL be one sub-module, hs_word_fifo, with push, pop, full, empty, count and head-data ports.
- The byte packer and busy logic SHALL stay in hs_rx_packer.

Verification
REQ-027 Basic pack: send bytes 0x11, 0x22, 0x33, 0x44 with out_ready=1.
- Required: out_valid=1 one cycle after the 0x44 byte, with out_data=0x44332211 for exactly one cycle.
REQ-028 Back-pressure: send 12 bytes 0x01..0x0C with out_ready=0.
- Required: busy=1 starting the cycle after the third word is pushed.
- Required: fifo_count=3 and out_data=0x04030201 held stable.
REQ-029 Overflow: send 20 bytes with out_ready=0.
- Required: the 5th word is dropped and overflow=1 from the next cycle.
- Required: draining gives exactly 4 words, in order.
REQ-030 Simultaneous push and pop with the FIFO full (count=4): complete a word while out_ready=1.
- Required: no overflow, count stays 4, and the new word appears last in the drain order.
REQ-031 Mid-word reset: send 0xAA and 0xBB, pulse rst_n low, then send 0x01..0x04.
- Required: output word is 0x04030201, overflow=0, busy=0.

Source files
------------

// File: rtl/hs_rx_packer_pkg.sv
// Shared defaults, derived widths and the packed word type for the
// handshake receive packer and its word FIFO.
package hs_rx_packer_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_PACK  = 4;
    localparam int DEF_DEPTH = 4;

    // Pointer indexes DEPTH entries; count must also represent DEPTH itself.
    localparam int PTR_W = $clog2(DEF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [DEF_WIDTH*DEF_PACK-1:0] word_t;

endpackage

// File: rtl/hs_word_fifo.sv
// Output word FIFO: registered memory, pointers wrapping modulo DEPTH,
// push accepted when not full or when a pop frees a slot in the same cycle.
module hs_word_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [DW-1:0]              push_data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [DW-1:0]              head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        empty_o  = (count_q == '0);
        full_o   = (count_q == CW'(DEPTH));
        do_pop   = pop_i && !empty_o;
        // When full, the slot being written is the one being read out this cycle.
        do_push  = push_i && (!full_o || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        count_o = count_q;
        head_o  = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/hs_rx_packer.sv
// Packs WIDTH-bit bytes from a handshake destination into little-endian
// WIDTH*PACK-bit words, buffers them in a word FIFO and raises advisory busy.
module hs_rx_packer
    import hs_rx_packer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PACK  = DEF_PACK,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH*PACK-1:0]   out_data,
    output logic                    overflow
);

    localparam int BC_W   = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int WORD_W = WIDTH * PACK;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0] partial_q, partial_d;
    logic [WORD_W-1:0] word_asm;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;
    logic              word_push;
    logic              pop_acc;
    logic              push_acc;
    logic [CW-1:0]     count_nxt;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [WORD_W-1:0] fifo_head;

    // out_valid/out_ready: the head word transfers in every cycle where both
    // are 1; out_valid comes from FIFO state only and never waits on out_ready.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        partial_d  = partial_q;
        word_asm   = partial_q;
        word_push  = 1'b0;
        if (in_valid) begin
            for (int k = 0; k < PACK; k++) begin
                if (byte_cnt_q == BC_W'(k)) begin
                    word_asm[k*WIDTH +: WIDTH] = in_data;
                end
            end
            if (byte_cnt_q == BC_W'(PACK - 1)) begin
                word_push  = 1'b1;
                byte_cnt_d = '0;
                partial_d  = '0;
            end else begin
                byte_cnt_d = byte_cnt_q + BC_W'(1);
                partial_d  = word_asm;
            end
        end

        pop_acc    = out_valid && out_ready;
        push_acc   = word_push && (!fifo_full || pop_acc);
        count_nxt  = fifo_count + CW'(push_acc) - CW'(pop_acc);
        // Busy one word early so bytes still in the synchronizer have room.
        busy_d     = (count_nxt >= CW'(DEPTH - 1));
        overflow_d = overflow_q || (word_push && !push_acc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            partial_q  <= '0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            partial_q  <= partial_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    hs_word_fifo #(
        .DW    (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (word_push),
        .push_data_i (word_asm),
        .pop_i       (out_ready),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_hs_rx_packer.sv
// Directed self-checking bench for hs_rx_packer: packing, back-pressure,
// overflow, full-FIFO push/pop and mid-word reset.
module tb_hs_rx_packer;
    import hs_rx_packer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    word_t       out_data;
    logic        overflow;

    word_t       exp_q[$];
    int          n_cmp;
    int          n_bad;

    hs_rx_packer #(
        .WIDTH (8),
        .PACK  (4),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks: inputs change on the falling edge, outputs sampled there too
    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n_exp);
        int got_n;
        got_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (!out_valid) break;
            if (exp_q.size() == 0) check("drain_extra", 64'd1, 64'd0);
            else check("drain_word", out_data, exp_q.pop_front());
            got_n++;
            out_ready = 1'b1;
        end
        out_ready = 1'b0;
        check("drain_count", got_n, n_exp);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // reset state
        do_reset();
        @(negedge clk);
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_data", out_data, 32'h0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_count", dut.u_fifo.count_o, 3'd0);

        // basic pack with out_ready=1
        out_ready = 1'b1;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        idle();
        check("basic_valid", out_valid, 1'b1);
        check("basic_data", out_data, 32'h44332211);
        idle();
        check("basic_valid_1cyc", out_valid, 1'b0);
        check("basic_busy", busy, 1'b0);
        out_ready = 1'b0;

        // back-pressure: three words, busy after the third
        do_reset();
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        exp_q.push_back(32'h0C0B0A09);
        for (int i = 1; i <= 12; i++) begin
            send_byte(8'(i));
            if (i == 12) check("bp_busy_early", busy, 1'b0);
        end
        idle();
        check("bp_busy", busy, 1'b1);
        check("bp_count", dut.u_fifo.count_o, 3'd3);
        check("bp_data", out_data, 32'h04030201);
        repeat (3) idle();
        check("bp_data_stable", out_data, 32'h04030201);
        check("bp_valid", out_valid, 1'b1);
        check("bp_ovf", overflow, 1'b0);
        drain(3);

        // overflow: fifth word dropped
        do_reset();
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        exp_q.push_back(32'h0C0B0A09);
        exp_q.push_back(32'h100F0E0D);
        for (int i = 1; i <= 20; i++) begin
            send_byte(8'(i));
            if (i == 20) begin
                check("ovf_early", overflow, 1'b0);
                check("ovf_count_full", dut.u_fifo.count_o, 3'd4);
            end
        end
        idle();
        check("ovf_set", overflow, 1'b1);
        check("ovf_count", dut.u_fifo.count_o, 3'd4);
        check("ovf_busy", busy, 1'b1);
        drain(4);
        check("ovf_sticky", overflow, 1'b1);

        // mid-word reset clears partial word and sticky overflow
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mrst_ovf_async", overflow, 1'b0);
        check("mrst_valid_async", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        idle();
        check("mrst_valid", out_valid, 1'b1);
        check("mrst_data", out_data, 32'h04030201);
        check("mrst_ovf", overflow, 1'b0);
        check("mrst_busy", busy, 1'b0);
        exp_q.push_back(32'h04030201);
        drain(1);

        // simultaneous push and pop while full
        do_reset();
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        exp_q.push_back(32'h0C0B0A09);
        exp_q.push_back(32'h100F0E0D);
        for (int i = 1; i <= 16; i++) send_byte(8'(i));
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        send_byte(8'hA4);
        out_ready = 1'b1;
        check("pp_head", out_data, exp_q.pop_front());
        check("pp_count_before", dut.u_fifo.count_o, 3'd4);
        exp_q.push_back(32'hA4A3A2A1);
        idle();
        out_ready = 1'b0;
        check("pp_count", dut.u_fifo.count_o, 3'd4);
        check("pp_ovf", overflow, 1'b0);
        check("pp_next_head", out_data, 32'h08070605);
        drain(4);
        check("pp_ovf_end", overflow, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
